lc3_alu_seq: RTL and testbench
==============================

Name: lc3_alu_seq

Overview:
- Registered, handshaked, parametrised successor to the LC-3 combinational ALU.
- Sits between register-read and writeback in the LC-3 datapath.
- Adds operand-B select (register or sign-extended immediate), SUB/shift ops and a multi-cycle multiply.
- Produces LC-3 NZP condition codes alongside each result.

Parameters:
WIDTH, 16, datapath width in bits (>=8, power of 2)
IMM_W, 5, immediate field width; sign-extended to WIDTH
MUL_EN, 1, 1 = opcode MUL implemented; 0 = MUL yields 0

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
in_valid  in  1  request valid
in_ready  out  1  block can accept a request this cycle
opcode  in  3  000 ADD, 001 AND, 010 NOT, 011 PASS, 100 SUB, 101 SHL, 110 SRA, 111 MUL
sr1  in  WIDTH  operand A
sr2  in  WIDTH  operand B register source
imm  in  IMM_W  immediate field
use_imm  in  1  1 = B is sign-extended imm, 0 = B is sr2
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  ALU result
nzp  out  3  {N,Z,P} of result
busy  out  1  multiply in progress

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - out_valid=0, result=0, nzp=3'b010, busy=0, FSM=IDLE.
  - Any in-flight MUL is aborted; no output is produced for it.
- Operand B: use_imm ? {{(WIDTH-IMM_W){imm[IMM_W-1]}},imm} : sr2.
- Accept: transfer when in_valid && in_ready. in_ready = (state==IDLE) && (!out_valid || out_ready).
- Output holds: result/nzp/out_valid stay stable while out_valid && !out_ready.
- Output pop: on out_valid && out_ready with no new completion, out_valid drops next cycle.
- Single-cycle ops, latency 1: result and out_valid=1 register on the edge after acceptance.
  - Back-to-back throughput is 1/cycle when out_ready is held high.
- Operations, all results modulo 2^WIDTH, carries dropped:
  - ADD: A+B.
  - AND: A&B.
  - NOT: ~A.
  - PASS: B.
  - SUB: A-B.
  - SHL: A << B[log2(WIDTH)-1:0].
  - SRA: arithmetic right shift of A by the same amount.
- MUL (MUL_EN=1): unsigned shift-add, low WIDTH bits of A*B.
  - FSM: IDLE -> MUL on accept, with busy=1 from the next cycle.
  - MUL runs a WIDTH-iteration counter, one partial product per cycle.
  - On the last iteration: register result, set out_valid=1, return to IDLE, busy=0.
  - Latency: WIDTH+1 cycles from accept to out_valid (17 for WIDTH=16).
  - in_ready=0 throughout MUL.
- MUL (MUL_EN=0): single-cycle, result=0.
- NZP, computed from the registered result:
  - N = result[WIDTH-1].
  - Z = (result==0).
  - P = !N && !Z.
  - Exactly one bit is set at all times.
- Simultaneous pop + accept: the old result is consumed and the new result appears next edge; out_valid stays 1 with no bubble.
- Input sampling: inputs are sampled only at acceptance; changes to sr1/sr2/imm during MUL have no effect.
- in_valid ignored while in_ready=0; no request is stored.

Test Plan:
- Reset: hold rst_n=0 two cycles mid-MUL -> out_valid=0, result=0, nzp=010, busy=0, in_ready=1 after release.
- ADD imm: sr1=0x0005, imm=5'b11101 (-3), use_imm=1 -> result=0x0002, nzp=001 one cycle later.
- Wrap and flags:
  - SUB sr1=0, sr2=1 -> result=0xFFFF, nzp=100.
  - AND 0xF0F0 & 0x0F0F -> 0x0000, nzp=010.
- Shifts: SRA 0x8000 by sr2=4 -> 0xF800. SHL 0x0001 by sr2=0x0013 (amount 3) -> 0x0008.
- MUL: 0x0123*0x0010 -> 0x1230 exactly 17 cycles after accept.
  - busy=1 and in_ready=0 throughout.
  - A request offered during MUL is not accepted.
- Backpressure and streaming:
  - out_ready=0 with a result held -> result/nzp stable, in_ready=0.
  - Then out_ready=1 with a new ADD offered -> pop and accept same cycle, next result out_valid with no gap.

Source files
------------

// File: rtl/lc3_alu_seq.sv
// Registered, handshaked LC-3 ALU with operand-B select, shifts and a
// multi-cycle shift-add multiplier. NZP flags are derived from the result register.
module lc3_alu_seq #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned IMM_W  = 5,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] sr1,
    input  logic [WIDTH-1:0] sr2,
    input  logic [IMM_W-1:0] imm,
    input  logic             use_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       nzp,
    output logic             busy
);

    localparam int unsigned SH_W = $clog2(WIDTH);

    localparam logic [2:0] OpAdd  = 3'b000;
    localparam logic [2:0] OpAnd  = 3'b001;
    localparam logic [2:0] OpNot  = 3'b010;
    localparam logic [2:0] OpPass = 3'b011;
    localparam logic [2:0] OpSub  = 3'b100;
    localparam logic [2:0] OpShl  = 3'b101;
    localparam logic [2:0] OpSra  = 3'b110;
    localparam logic [2:0] OpMul  = 3'b111;

    typedef enum logic {StIdle, StMul} state_e;

    state_e            state_q, state_d;
    logic [SH_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              out_valid_q, out_valid_d;

    logic [WIDTH-1:0]  operand_b;
    logic [SH_W-1:0]   shamt;
    logic [WIDTH-1:0]  alu_res;
    logic [WIDTH-1:0]  partial;
    logic              accept;
    logic              is_mul;
    logic              last_iter;
    logic              out_free;

    assign operand_b = use_imm ? {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm} : sr2;
    assign shamt     = operand_b[SH_W-1:0];
    assign out_free  = !out_valid_q || out_ready;
    assign in_ready  = (state_q == StIdle) && out_free;
    assign accept    = in_valid && in_ready;
    assign is_mul    = MUL_EN && (opcode == OpMul);
    assign last_iter = (cnt_q == SH_W'(WIDTH - 1));
    // Accumulator after adding this iteration's partial product.
    assign partial   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // Single-cycle operation results; MUL here only matters when MUL_EN=0.
    always_comb begin
        alu_res = '0;
        case (opcode)
            OpAdd:   alu_res = sr1 + operand_b;
            OpAnd:   alu_res = sr1 & operand_b;
            OpNot:   alu_res = ~sr1;
            OpPass:  alu_res = operand_b;
            OpSub:   alu_res = sr1 - operand_b;
            OpShl:   alu_res = sr1 << shamt;
            OpSra:   alu_res = $signed(sr1) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    // Next-state for the FSM, multiplier datapath and output register.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (is_mul) begin
                        state_d  = StMul;
                        cnt_d    = '0;
                        acc_d    = '0;
                        mcand_d  = sr1;
                        mplier_d = operand_b;
                    end else begin
                        result_d    = alu_res;
                        out_valid_d = 1'b1;
                    end
                end
            end
            StMul: begin
                if (!last_iter) begin
                    acc_d    = partial;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + SH_W'(1);
                end else if (out_free) begin
                    // Final step only retires once the output slot is free,
                    // so a held result is never overwritten.
                    result_d    = partial;
                    out_valid_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign result    = result_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == StMul);
    assign nzp       = {result_q[WIDTH-1],
                        (result_q == '0),
                        !result_q[WIDTH-1] && (result_q != '0)};

endmodule

// File: tb/tb_lc3_alu_seq.sv
// Self-checking bench for lc3_alu_seq: vector table, scoreboard, corner-case sequences.
module tb_lc3_alu_seq;

    localparam logic [2:0] OpAdd  = 3'b000;
    localparam logic [2:0] OpAnd  = 3'b001;
    localparam logic [2:0] OpNot  = 3'b010;
    localparam logic [2:0] OpPass = 3'b011;
    localparam logic [2:0] OpSub  = 3'b100;
    localparam logic [2:0] OpShl  = 3'b101;
    localparam logic [2:0] OpSra  = 3'b110;
    localparam logic [2:0] OpMul  = 3'b111;

    typedef struct packed {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [4:0]  imm;
        logic        use_imm;
        logic [15:0] res;
        logic [2:0]  nzp;
    } vec_t;

    typedef struct packed {
        logic [15:0] res;
        logic [2:0]  nzp;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  opcode;
    logic [15:0] sr1;
    logic [15:0] sr2;
    logic [4:0]  imm;
    logic        use_imm;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [2:0]  nzp;
    logic        busy;

    int   checks;
    int   errors;
    logic bp;
    exp_t cur_exp;
    exp_t sb_q[$];
    vec_t vecs[14];

    lc3_alu_seq #(
        .WIDTH (16),
        .IMM_W (5),
        .MUL_EN(1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .opcode   (opcode),
        .sr1      (sr1),
        .sr2      (sr2),
        .imm      (imm),
        .use_imm  (use_imm),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .nzp      (nzp),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [15:0] a,
                                   input logic [15:0] b);
        logic [31:0] p;
        exp_t e;
        case (op)
            OpAdd:   e.res = a + b;
            OpAnd:   e.res = a & b;
            OpNot:   e.res = ~a;
            OpPass:  e.res = b;
            OpSub:   e.res = a - b;
            OpShl:   e.res = a << b[3:0];
            OpSra:   e.res = $signed(a) >>> b[3:0];
            default: begin
                p = a * b;
                e.res = p[15:0];
            end
        endcase
        e.nzp = {e.res[15], e.res == 16'h0, !e.res[15] && e.res != 16'h0};
        return e;
    endfunction

    // Scoreboard: push on accept, pop and compare on output handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected got %h/%b want none", result, nzp);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    if (result !== e.res || nzp !== e.nzp) begin
                        errors++;
                        $display("FAIL sb_result got %h/%b want %h/%b", result, nzp, e.res, e.nzp);
                    end
                end
            end
            if (out_valid) begin
                checks++;
                if (!$onehot(nzp)) begin
                    errors++;
                    $display("FAIL nzp_onehot got %b want one bit set", nzp);
                end
            end
            if (in_valid && in_ready) sb_q.push_back(cur_exp);
        end
    end

    task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [4:0] im, input logic ui, input exp_t e);
        int n;
        opcode   = op;
        sr1      = a;
        sr2      = b;
        imm      = im;
        use_imm  = ui;
        cur_exp  = e;
        in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                chk("send_timeout", 32'd0, 32'd1);
                break;
            end
            @(posedge clk);
            #1;
            if (bp) out_ready = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (bp) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while (sb_q.size() != 0 || out_valid || busy) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                chk("drain_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic [4:0]  ri;
        logic        ru;
        logic [2:0]  ro;
        int          lat;
        logic        seen;

        checks    = 0;
        errors    = 0;
        bp        = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        opcode    = OpAdd;
        sr1       = '0;
        sr2       = '0;
        imm       = '0;
        use_imm   = 1'b0;
        cur_exp   = '0;

        vecs[0]  = '{OpAdd,  16'h0005, 16'h0000, 5'b11101, 1'b1, 16'h0002, 3'b001};
        vecs[1]  = '{OpSub,  16'h0000, 16'h0001, 5'b00000, 1'b0, 16'hFFFF, 3'b100};
        vecs[2]  = '{OpAnd,  16'hF0F0, 16'h0F0F, 5'b00000, 1'b0, 16'h0000, 3'b010};
        vecs[3]  = '{OpSra,  16'h8000, 16'h0004, 5'b00000, 1'b0, 16'hF800, 3'b100};
        vecs[4]  = '{OpShl,  16'h0001, 16'h0013, 5'b00000, 1'b0, 16'h0008, 3'b001};
        vecs[5]  = '{OpNot,  16'h00FF, 16'h1234, 5'b00000, 1'b0, 16'hFF00, 3'b100};
        vecs[6]  = '{OpPass, 16'h1111, 16'h2222, 5'b01111, 1'b1, 16'h000F, 3'b001};
        vecs[7]  = '{OpAdd,  16'h7FFF, 16'h0001, 5'b00000, 1'b0, 16'h8000, 3'b100};
        vecs[8]  = '{OpPass, 16'hABCD, 16'h0000, 5'b00000, 1'b0, 16'h0000, 3'b010};
        vecs[9]  = '{OpSra,  16'h8001, 16'h0001, 5'b00000, 1'b0, 16'hC000, 3'b100};
        vecs[10] = '{OpMul,  16'h0123, 16'h0010, 5'b00000, 1'b0, 16'h1230, 3'b001};
        vecs[11] = '{OpSub,  16'h0003, 16'h0000, 5'b10000, 1'b1, 16'h0013, 3'b001};
        vecs[12] = '{OpMul,  16'hFFFF, 16'hFFFF, 5'b00000, 1'b0, 16'h0001, 3'b001};
        vecs[13] = '{OpShl,  16'h8001, 16'h0001, 5'b00000, 1'b0, 16'h0002, 3'b001};

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_result", result, 16'h0000);
        chk("rst_nzp", nzp, 3'b010);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Table vectors, streamed back-to-back with the consumer always ready.
        for (int i = 0; i < 14; i++) begin
            send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].use_imm,
                 '{vecs[i].res, vecs[i].nzp});
        end
        drain();

        // MUL latency, busy/in_ready during MUL, operand changes ignored,
        // request offered mid-MUL not taken until MUL retires.
        opcode   = OpMul;
        sr1      = 16'h0123;
        sr2      = 16'h0010;
        use_imm  = 1'b0;
        cur_exp  = '{16'h1230, 3'b001};
        in_valid = 1'b1;
        @(negedge clk);
        chk("mul_accept_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        opcode  = OpAdd;
        sr1     = 16'h0001;
        sr2     = 16'h0001;
        cur_exp = '{16'h0002, 3'b001};
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = k;
                break;
            end
            chk("mul_busy", busy, 1'b1);
            chk("mul_in_ready", in_ready, 1'b0);
        end
        chk("mul_latency", lat, 17);
        chk("mul_busy_done", busy, 1'b0);
        chk("mul_result", result, 16'h1230);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("mul_then_add_valid", out_valid, 1'b1);
        chk("mul_then_add_result", result, 16'h0002);
        drain();

        // Backpressure hold, then pop + accept in the same cycle.
        out_ready = 1'b0;
        send(OpAdd, 16'h0010, 16'h0000, 5'b00011, 1'b1, '{16'h0013, 3'b001});
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_result", result, 16'h0013);
            chk("hold_nzp", nzp, 3'b001);
            chk("hold_in_ready", in_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        opcode    = OpAdd;
        sr1       = 16'h7FFF;
        sr2       = 16'h7FFF;
        use_imm   = 1'b0;
        cur_exp   = '{16'hFFFE, 3'b100};
        in_valid  = 1'b1;
        @(negedge clk);
        chk("popaccept_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("popaccept_no_gap", out_valid, 1'b1);
        chk("popaccept_result", result, 16'hFFFE);
        chk("popaccept_nzp", nzp, 3'b100);
        drain();

        // Random stream with random consumer backpressure.
        bp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = 16'($urandom);
            rb = 16'($urandom);
            ri = 5'($urandom);
            ru = 1'($urandom_range(0, 1));
            send(ro, ra, rb, ri, ru, model(ro, ra, ru ? {{11{ri[4]}}, ri} : rb));
        end
        bp = 1'b0;
        drain();

        // Reset held two cycles in the middle of a MUL aborts it.
        send(OpMul, 16'h0055, 16'h0033, 5'b00000, 1'b0, model(OpMul, 16'h0055, 16'h0033));
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_q.delete();
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_result", result, 16'h0000);
        chk("midrst_nzp", nzp, 3'b010);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid || busy) seen = 1'b1;
        end
        chk("midrst_no_output", seen, 1'b0);

        // Post-reset sanity: a fresh op still works.
        @(posedge clk);
        #1;
        send(OpSub, 16'h0001, 16'h0000, 5'b00001, 1'b1, '{16'h0000, 3'b010});
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
